// File: rtl/mem_map_pkg.sv
// Memory map constants shared by the bus responder.
// Region codes come from ADDR[15:12].
package mem_map_pkg;

   localparam logic [3:0] REG_RAM = 4'h0;
   localparam logic [3:0] REG_LED = 4'h1;
   localparam logic [3:0] REG_HEX = 4'h2;
   localparam logic [3:0] REG_SW  = 4'h3;

   localparam logic [6:0] HEX_BLANK = 7'h7F;
   localparam int         NUM_HEX   = 6;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous word RAM, read-first.
// No reset so it maps onto block RAM.
module sync_ram #(
   parameter int AW = 7,
   parameter int DW = 16
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
      r_q <= r_mem[i_addr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/mem_io_responder.sv
// Bus responder: RAM, LED and HEX registers, synchronized switches.
// Read data returns on DIN one cycle after the address.
module mem_io_responder
   import mem_map_pkg::*;
#(
   parameter int RAM_AW = 7,
   parameter int LED_W  = 10,
   parameter int SW_W   = 10
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [15:0]      ADDR,
   input  logic [15:0]      DOUT,
   input  logic             W,
   output logic [15:0]      DIN,
   input  logic [SW_W-1:0]  SW,
   output logic [LED_W-1:0] LEDR,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX3,
   output logic [6:0]       HEX4,
   output logic [6:0]       HEX5
);

   logic [3:0]       w_region;
   logic [2:0]       w_hex_sel;
   logic             w_ram_we;
   logic [15:0]      w_ram_rd;
   logic [15:0]      w_io_rd;
   logic             w_unused;

   logic [LED_W-1:0] r_led;
   logic [6:0]       r_hex [NUM_HEX];
   logic [SW_W-1:0]  r_sw_s1;
   logic [SW_W-1:0]  r_sw_s2;
   logic [15:0]      r_io_rd;
   logic             r_sel_ram;

   assign w_region  = ADDR[15:12];
   assign w_hex_sel = ADDR[2:0];
   assign w_ram_we  = W && (w_region == REG_RAM);
   assign w_unused  = ^{ADDR[11:RAM_AW], DOUT[15:LED_W]};

   sync_ram #(
      .AW (RAM_AW),
      .DW (16)
   ) u_ram (
      .i_clk   (Clock),
      .i_we    (w_ram_we),
      .i_addr  (ADDR[RAM_AW-1:0]),
      .i_wdata (DOUT),
      .o_rdata (w_ram_rd)
   );

   always_comb begin
      w_io_rd = '0;
      case (w_region)
         REG_LED: w_io_rd = {{(16-LED_W){1'b0}}, r_led};
         REG_HEX: begin
            for (int i = 0; i < NUM_HEX; i++)
               if (w_hex_sel == i[2:0])
                  w_io_rd = {9'b0, r_hex[i]};
         end
         REG_SW:  w_io_rd = {{(16-SW_W){1'b0}}, r_sw_s2};
         default: w_io_rd = '0;
      endcase
   end

   // I/O reads are captured here; RAM data is already registered in u_ram
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_led     <= '0;
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
         r_io_rd   <= '0;
         r_sel_ram <= 1'b0;
         for (int i = 0; i < NUM_HEX; i++)
            r_hex[i] <= HEX_BLANK;
      end else begin
         r_sw_s1   <= SW;
         r_sw_s2   <= r_sw_s1;
         r_io_rd   <= w_io_rd;
         r_sel_ram <= (w_region == REG_RAM);
         if (W && (w_region == REG_LED))
            r_led <= DOUT[LED_W-1:0];
         for (int i = 0; i < NUM_HEX; i++)
            if (W && (w_region == REG_HEX) && (w_hex_sel == i[2:0]))
               r_hex[i] <= DOUT[6:0];
      end
   end

   assign DIN  = r_sel_ram ? w_ram_rd : r_io_rd;
   assign LEDR = r_led;
   assign HEX0 = r_hex[0];
   assign HEX1 = r_hex[1];
   assign HEX2 = r_hex[2];
   assign HEX3 = r_hex[3];
   assign HEX4 = r_hex[4];
   assign HEX5 = r_hex[5];

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_mem_io_responder;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [15:0] ADDR;
   logic [15:0] DOUT;
   logic        W;
   logic [15:0] DIN;
   logic [9:0]  SW;
   logic [9:0]  LEDR;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int n_chk  = 0;
   int n_pass = 0;

   mem_io_responder dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .ADDR   (ADDR),
      .DOUT   (DOUT),
      .W      (W),
      .DIN    (DIN),
      .SW     (SW),
      .LEDR   (LEDR),
      .HEX0   (HEX0),
      .HEX1   (HEX1),
      .HEX2   (HEX2),
      .HEX3   (HEX3),
      .HEX4   (HEX4),
      .HEX5   (HEX5)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_hex(input string tag, input logic [6:0] h0,
                          input logic [6:0] h1, input logic [6:0] h2,
                          input logic [6:0] h3, input logic [6:0] h4,
                          input logic [6:0] h5);
      chk({tag, "_hex0"}, {9'b0, HEX0}, {9'b0, h0});
      chk({tag, "_hex1"}, {9'b0, HEX1}, {9'b0, h1});
      chk({tag, "_hex2"}, {9'b0, HEX2}, {9'b0, h2});
      chk({tag, "_hex3"}, {9'b0, HEX3}, {9'b0, h3});
      chk({tag, "_hex4"}, {9'b0, HEX4}, {9'b0, h4});
      chk({tag, "_hex5"}, {9'b0, HEX5}, {9'b0, h5});
   endtask

   initial begin
      Resetn = 1'b0;
      W      = 1'b0;
      ADDR   = 16'h0000;
      DOUT   = 16'h0000;
      SW     = 10'h000;
      #12;
      chk("rst_din", DIN, 16'h0000);
      chk("rst_led", {6'b0, LEDR}, 16'h0000);
      chk_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      tick();
      Resetn = 1'b1;

      ADDR = 16'h1000;
      tick();
      chk("rd_led0", DIN, 16'h0000);
      for (int d = 0; d < 6; d++) begin
         ADDR = 16'h2000 + 16'(d);
         tick();
         chk($sformatf("rd_hex%0d", d), DIN, 16'h007F);
      end

      W = 1'b1; ADDR = 16'h0005; DOUT = 16'hBEEF;
      tick();
      W = 1'b0;
      tick();
      chk("ram_rd5", DIN, 16'hBEEF);
      ADDR = 16'h0085;
      tick();
      chk("ram_alias", DIN, 16'hBEEF);

      W = 1'b1; ADDR = 16'h0003; DOUT = 16'h1111;
      tick();
      DOUT = 16'h2222;
      tick();
      chk("ram_rdfirst", DIN, 16'h1111);
      W = 1'b0;
      tick();
      chk("ram_new", DIN, 16'h2222);

      W = 1'b1; ADDR = 16'h1000; DOUT = 16'hFFFF;
      tick();
      chk("led_wr", {6'b0, LEDR}, 16'h03FF);
      chk("led_rdfirst", DIN, 16'h0000);
      W = 1'b0;
      tick();
      chk("led_rd", DIN, 16'h03FF);

      W = 1'b1; ADDR = 16'h2004; DOUT = 16'h0040;
      tick();
      chk("hex4_rdfirst", DIN, 16'h007F);
      chk_hex("hex4wr", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F);
      ADDR = 16'h2007; DOUT = 16'h0000;
      tick();
      chk("hex7_rd", DIN, 16'h0000);
      chk_hex("hex7wr", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F);
      W = 1'b0; ADDR = 16'h2004;
      tick();
      chk("hex4_rd", DIN, 16'h0040);

      SW = 10'h2A5; ADDR = 16'h3000;
      repeat (4) tick();
      chk("sw_steady", DIN, 16'h02A5);
      SW = 10'h15A;
      tick();
      chk("sw_lag1", DIN, 16'h02A5);
      tick();
      tick();
      chk("sw_new", DIN, 16'h015A);
      W = 1'b1; DOUT = 16'hFFFF;
      tick();
      W = 1'b0;
      tick();
      chk("sw_wr_ign", DIN, 16'h015A);

      ADDR = 16'h7123;
      tick();
      chk("unmapped_rd", DIN, 16'h0000);
      W = 1'b1; ADDR = 16'h9000; DOUT = 16'h1234;
      tick();
      W = 1'b0;
      chk("unmapped_led", {6'b0, LEDR}, 16'h03FF);
      chk_hex("unmapped", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F);
      ADDR = 16'h0005;
      tick();
      chk("unmapped_ram", DIN, 16'hBEEF);

      ADDR = 16'h1000;
      tick();
      chk("pre_rst_din", DIN, 16'h03FF);
      #2;
      Resetn = 1'b0;
      #1;
      chk("mid_rst_din", DIN, 16'h0000);
      chk("mid_rst_led", {6'b0, LEDR}, 16'h0000);
      chk_hex("mid_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      tick();
      Resetn = 1'b1;
      ADDR = 16'h0005;
      tick();
      chk("ram_kept", DIN, 16'hBEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
